// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM encoding and
// address-field widths derived from the LINES / WORDS_PER_LINE parameters.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        UPDATE   = 2'd2
    } icache_state_e;

    localparam int BYTE_OFF_W = 2;

    function automatic int offset_w(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int index_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int block_w(input int words_per_line);
        return 32 - offset_w(words_per_line) - BYTE_OFF_W;
    endfunction

    function automatic int tag_w(input int lines, input int words_per_line);
        return block_w(words_per_line) - index_w(lines);
    endfunction

endpackage

// File: rtl/instruction_cache_if.sv
// Fetch-side and memory-side signals of the instruction cache. The cache is the
// slave (responder to the PC, requester towards memory); master is the environment.
interface instruction_cache_if #(
    parameter int WORDS_PER_LINE = 4
);
    import icache_pkg::*;

    localparam int BLK_W = block_w(WORDS_PER_LINE);

    logic [31:0]                  ADDRESS;
    logic [31:0]                  INSTRUCTION;
    logic                         BUSYWAIT;
    logic                         MEM_READ;
    logic [BLK_W-1:0]             MEM_ADDRESS;
    logic [32*WORDS_PER_LINE-1:0] MEM_READDATA;
    logic                         MEM_VALID;

    modport slave (
        input  ADDRESS, MEM_READDATA, MEM_VALID,
        output INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
    );

    modport master (
        output ADDRESS, MEM_READDATA, MEM_VALID,
        input  INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
    );

endinterface

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays of the cache: combinational read by index, synchronous
// refill write, and synchronous clear of all valid bits (clear wins over write).
module icache_line_store import icache_pkg::*; #(
    parameter  int LINES  = 8,
    parameter  int TAG_W  = 25,
    parameter  int DATA_W = 128,
    localparam int IDX_W  = index_w(LINES)
) (
    input  logic              clk_i,
    input  logic              clr_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  widx_i,
    input  logic [TAG_W-1:0]  wtag_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  ridx_i,
    output logic              rvalid_o,
    output logic [TAG_W-1:0]  rtag_o,
    output logic [DATA_W-1:0] rdata_o
);

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES];

    // Valid bits: cleared together, set by a refill write
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[widx_i] <= 1'b1;
        end
    end

    // Tag and data payload of the refilled line
    always_ff @(posedge clk_i) begin
        if (we_i && !clr_i) begin
            tag_q[widx_i]  <= wtag_i;
            data_q[widx_i] <= wdata_i;
        end
    end

    assign rvalid_o = valid_q[ridx_i];
    assign rtag_o   = tag_q[ridx_i];
    assign rdata_o  = data_q[ridx_i];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: zero-latency hits, single-line refill
// on a miss. Define ICACHE_STATS_EN to add the HIT_COUNT / MISS_COUNT outputs.
module instruction_cache import icache_pkg::*; #(
    parameter int LINES          = 8,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                CLOCK,
    input  logic                RESET,
    instruction_cache_if.slave  bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]         HIT_COUNT,
    output logic [31:0]         MISS_COUNT
`endif
);

    localparam int OFF_W  = offset_w(WORDS_PER_LINE);
    localparam int IDX_W  = index_w(LINES);
    localparam int TAG_W  = tag_w(LINES, WORDS_PER_LINE);
    localparam int BLK_W  = block_w(WORDS_PER_LINE);
    localparam int DATA_W = 32 * WORDS_PER_LINE;

    icache_state_e     state_q, state_d;
    logic [BLK_W-1:0]  miss_addr_q, miss_addr_d;
    logic [DATA_W-1:0] refill_q, refill_d;

    logic [OFF_W-1:0]  word_sel_s;
    logic [IDX_W-1:0]  idx_s;
    logic [TAG_W-1:0]  tag_s;
    logic              line_valid_s;
    logic [TAG_W-1:0]  line_tag_s;
    logic [DATA_W-1:0] line_data_s;
    logic              hit_s;
    logic              busy_s;
    logic [31:0]       instr_s;
    logic              unused_addr_s;

    assign word_sel_s    = bus.ADDRESS[BYTE_OFF_W +: OFF_W];
    assign idx_s         = bus.ADDRESS[BYTE_OFF_W + OFF_W +: IDX_W];
    assign tag_s         = bus.ADDRESS[31 -: TAG_W];
    assign unused_addr_s = ^bus.ADDRESS[BYTE_OFF_W-1:0];

    icache_line_store #(
        .LINES  (LINES),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W)
    ) u_line_store (
        .clk_i    (CLOCK),
        .clr_i    (!RESET),
        .we_i     (state_q == UPDATE),
        .widx_i   (miss_addr_q[IDX_W-1:0]),
        .wtag_i   (miss_addr_q[BLK_W-1 -: TAG_W]),
        .wdata_i  (refill_q),
        .ridx_i   (idx_s),
        .rvalid_o (line_valid_s),
        .rtag_o   (line_tag_s),
        .rdata_o  (line_data_s)
    );

    assign hit_s = line_valid_s && (line_tag_s == tag_s);

    // Next-state, refill capture and lookup result
    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        refill_d    = refill_q;
        busy_s      = 1'b1;
        instr_s     = 32'd0;
        case (state_q)
            IDLE: begin
                if (hit_s) begin
                    busy_s  = 1'b0;
                    instr_s = line_data_s[{word_sel_s, 5'd0} +: 32];
                end else begin
                    state_d     = MEM_WAIT;
                    miss_addr_d = bus.ADDRESS[31 -: BLK_W];
                end
            end
            MEM_WAIT: begin
                if (bus.MEM_VALID) begin
                    refill_d = bus.MEM_READDATA;
                    state_d  = UPDATE;
                end else begin
                    state_d = MEM_WAIT;
                end
            end
            UPDATE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, miss address and refill buffer
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
            refill_q    <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            refill_q    <= refill_d;
        end
    end

    // Reset holds the fetch stage unstalled with a zero instruction
    assign bus.BUSYWAIT    = RESET ? busy_s  : 1'b0;
    assign bus.INSTRUCTION = RESET ? instr_s : 32'd0;
    assign bus.MEM_READ    = (state_q == MEM_WAIT);
    assign bus.MEM_ADDRESS = miss_addr_q;

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    // Hit counter per IDLE hit edge, miss counter per IDLE->MEM_WAIT transition
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
        end else if (state_q == IDLE) begin
            if (hit_s) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end else begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign HIT_COUNT  = hit_cnt_q;
    assign MISS_COUNT = miss_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Scoreboard bench for instruction_cache: a latency-programmable memory model
// answers refills; expected instructions are queued at fetch and popped on delivery.
module tb_instruction_cache;

    localparam int LINES = 8;
    localparam int WPL   = 4;

    logic                clk;
    logic                rst_n;
    logic                model_valid;
    logic                force_valid;
    logic [32*WPL-1:0]   model_data;
    int                  mem_lat;
    int                  n_cmp;
    int                  n_err;
    logic [31:0]         exp_q [$];

    instruction_cache_if #(.WORDS_PER_LINE(WPL)) bus ();

    assign bus.MEM_VALID    = model_valid | force_valid;
    assign bus.MEM_READDATA = model_data;

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    instruction_cache #(
        .LINES          (LINES),
        .WORDS_PER_LINE (WPL)
    ) dut (
        .CLOCK (clk),
        .RESET (rst_n),
        .bus   (bus)
`ifdef ICACHE_STATS_EN
        ,
        .HIT_COUNT  (hit_count),
        .MISS_COUNT (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory image: word at word-address w holds w + 1
    function automatic logic [32*WPL-1:0] line_of(input logic [31:0] blk);
        logic [32*WPL-1:0] l;
        l = '0;
        for (int i = 0; i < WPL; i++) begin
            l[i*32 +: 32] = (blk << 2) + 32'(i) + 32'd1;
        end
        return l;
    endfunction

    // Memory responder: MEM_VALID on the mem_lat-th cycle of MEM_READ
    initial begin : mem_model
        int cnt;
        cnt         = 0;
        model_valid = 1'b0;
        model_data  = '0;
        forever begin
            @(negedge clk);
            model_valid = 1'b0;
            if (bus.MEM_READ) begin
                cnt++;
                if (cnt == mem_lat) begin
                    model_valid = 1'b1;
                    model_data  = line_of(32'(bus.MEM_ADDRESS));
                    cnt         = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Drive one fetch (called at a negedge); returns at the negedge after delivery
    task automatic fetch(input logic [31:0] addr, input logic [31:0] sw_addr, input int sw_cyc,
                         input int lat, input int exp_busy, input logic [31:0] exp_blk,
                         input logic [31:0] sw_blk, input logic [31:0] exp_instr);
        int   busy;
        int   cyc;
        int   bursts;
        logic prev_rd;
        logic done;
        logic [31:0] e;
        busy    = 0;
        cyc     = 0;
        bursts  = 0;
        prev_rd = 1'b0;
        done    = 1'b0;
        mem_lat = lat;
        exp_q.push_back(exp_instr);
        bus.ADDRESS = addr;
        while (!done && cyc < 100) begin
            if (sw_cyc > 0 && busy == sw_cyc) bus.ADDRESS = sw_addr;
            #1;
            if (bus.BUSYWAIT) begin
                busy++;
                if (prev_rd && !bus.MEM_READ) bursts++;
                if (bus.MEM_READ) check_val("mem_address", 32'(bus.MEM_ADDRESS), (bursts == 0) ? exp_blk : sw_blk);
                prev_rd = bus.MEM_READ;
            end else begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                check_val("instruction", bus.INSTRUCTION, e);
                check_val("busy_cycles", 32'(busy), 32'(exp_busy));
                check_val("mem_read_idle", 32'(bus.MEM_READ), 32'd0);
                done = 1'b1;
            end
            cyc++;
            @(negedge clk);
        end
        check_val("fetch_done", 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        force_valid = 1'b0;
        mem_lat     = 1000;
        bus.ADDRESS = 32'd0;

        repeat (2) @(negedge clk);
        #1;
        check_val("rst_busywait", 32'(bus.BUSYWAIT), 32'd0);
        check_val("rst_instruction", bus.INSTRUCTION, 32'd0);
        check_val("rst_mem_read", 32'(bus.MEM_READ), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Cold fetch, then spatial hits in the same line
        fetch(32'h0000_0000, 32'd0, 0, 5, 7, 32'h0, 32'h0, 32'h0000_0001);
        fetch(32'h0000_0004, 32'd0, 0, 5, 0, 32'h0, 32'h0, 32'h0000_0002);
        fetch(32'h0000_0008, 32'd0, 0, 5, 0, 32'h0, 32'h0, 32'h0000_0003);
`ifdef ICACHE_STATS_EN
        check_val("miss_count", miss_count, 32'd1);
        check_val("hit_count", hit_count, 32'd3);
`endif
        fetch(32'h0000_000C, 32'd0, 0, 5, 0, 32'h0, 32'h0, 32'h0000_0004);

        // Conflict at index 0, then the evicted line misses again
        fetch(32'h0000_0080, 32'd0, 0, 1, 3, 32'h8, 32'h0, 32'h0000_0021);
        fetch(32'h0000_0000, 32'd0, 0, 3, 5, 32'h0, 32'h0, 32'h0000_0001);

        // Address switch during MEM_WAIT: refill for 0x10 completes, then 0x20 misses
        fetch(32'h0000_0010, 32'h0000_0020, 2, 5, 14, 32'h1, 32'h2, 32'h0000_0009);
        fetch(32'h0000_0010, 32'd0, 0, 5, 0, 32'h0, 32'h0, 32'h0000_0005);
        fetch(32'h0000_0020, 32'd0, 0, 5, 0, 32'h0, 32'h0, 32'h0000_0009);

        // Reset during MEM_WAIT aborts the refill; a late MEM_VALID is ignored
        mem_lat     = 1000;
        bus.ADDRESS = 32'h0000_0040;
        #1;
        check_val("abort_miss_busy", 32'(bus.BUSYWAIT), 32'd1);
        @(negedge clk);
        #1;
        check_val("abort_mem_read", 32'(bus.MEM_READ), 32'd1);
        check_val("abort_mem_address", 32'(bus.MEM_ADDRESS), 32'h4);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("inrst_busywait", 32'(bus.BUSYWAIT), 32'd0);
        check_val("inrst_instruction", bus.INSTRUCTION, 32'd0);
        @(negedge clk);
        #1;
        check_val("postrst_mem_read", 32'(bus.MEM_READ), 32'd0);
        force_valid = 1'b1;
        @(negedge clk);
        force_valid = 1'b0;
        rst_n       = 1'b1;
        fetch(32'h0000_0040, 32'd0, 0, 4, 6, 32'h4, 32'h0, 32'h0000_0011);
        fetch(32'h0000_0000, 32'd0, 0, 2, 4, 32'h0, 32'h0, 32'h0000_0001);

        check_val("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
